// File: rtl/ysyx_22050133_lsu_pkg.sv
// Shared definitions for the ysyx_22050133 MEM stage: access sizes, LSU states
// and byte-lane masks.
package npcdefine;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_D = 2'd3
   } lsu_size_e;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_RESP = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   localparam logic [7:0] MASK_B = 8'h01;
   localparam logic [7:0] MASK_H = 8'h03;
   localparam logic [7:0] MASK_W = 8'h0F;
   localparam logic [7:0] MASK_D = 8'hFF;

   function automatic logic [7:0] base_mask(input logic [1:0] size);
      case (lsu_size_e'(size))
         SIZE_B:  return MASK_B;
         SIZE_H:  return MASK_H;
         SIZE_W:  return MASK_W;
         default: return MASK_D;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      case (lsu_size_e'(size))
         SIZE_B:  return 1'b0;
         SIZE_H:  return off[0];
         SIZE_W:  return |off[1:0];
         default: return |off;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22050133_lsu_align.sv
// Byte-lane steering: shifts store data/strobes onto the doubleword bus and
// extracts right-aligned, zero-filled load data from a bus doubleword.
module ysyx_22050133_lsu_align
   import npcdefine::*;
(
   input  logic [1:0]  size,
   input  logic [2:0]  off,
   input  logic [63:0] wdata,
   input  logic [63:0] resp_rdata,
   output logic [63:0] bus_wdata,
   output logic [7:0]  bus_wmask,
   output logic [63:0] ld_data
);

   logic [7:0]  base;
   logic [63:0] shifted;

   assign base      = base_mask(size);
   assign bus_wmask = base << off;
   assign bus_wdata = wdata << {off, 3'b000};
   assign shifted   = resp_rdata >> {off, 3'b000};

   // Each result byte survives only if it lies inside the access size.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign ld_data[gi*8 +: 8] = shifted[gi*8 +: 8] & {8{base[gi]}};
      end
   endgenerate

endmodule

// File: rtl/ysyx_22050133_lsu.sv
// MEM-stage load/store unit: one aligned doubleword bus transaction per start,
// with fault detection for misaligned/conflicting accesses and a wait timeout.
module ysyx_22050133_lsu
   import npcdefine::*;
#(
   parameter int TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ren,
   input  logic        wen,
   input  logic [1:0]  size,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic        done,
   output logic [63:0] rdata,
   output logic        fault,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_wen,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_rdata
);

   lsu_state_e  state_reg, state_next;
   logic [31:0] cnt_reg;
   logic [1:0]  size_reg;
   logic [2:0]  off_reg;
   logic        fault_reg;
   logic [63:0] rdata_reg;
   logic        req_wen_reg;
   logic [63:0] req_addr_reg;
   logic [63:0] req_wdata_reg;
   logic [7:0]  req_wmask_reg;

   logic [1:0]  size_sel;
   logic [2:0]  off_sel;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic [63:0] ld_data;
   logic        access;
   logic        bad;
   logic        timeout_hit;

   assign access      = ren ^ wen;
   assign bad         = (ren & wen) | (access & misaligned(size, addr[2:0]));
   assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == 32'(TIMEOUT - 1));

   // In IDLE the aligner prepares the request from live operands; afterwards
   // it works on the latched ones so load extraction matches the request.
   assign size_sel = (state_reg == LSU_IDLE) ? size      : size_reg;
   assign off_sel  = (state_reg == LSU_IDLE) ? addr[2:0] : off_reg;

   ysyx_22050133_lsu_align u_align (
      .size       (size_sel),
      .off        (off_sel),
      .wdata      (wdata),
      .resp_rdata (mem_resp_rdata),
      .bus_wdata  (bus_wdata),
      .bus_wmask  (bus_wmask),
      .ld_data    (ld_data)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         LSU_IDLE: begin
            if (start) begin
               if (!access || bad) state_next = LSU_DONE;
               else                state_next = LSU_REQ;
            end
         end
         LSU_REQ: begin
            if (timeout_hit)        state_next = LSU_DONE;
            else if (mem_req_ready) state_next = LSU_RESP;
         end
         LSU_RESP: begin
            if (mem_resp_valid || timeout_hit) state_next = LSU_DONE;
         end
         default: state_next = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= LSU_IDLE;
         cnt_reg       <= '0;
         size_reg      <= '0;
         off_reg       <= '0;
         fault_reg     <= 1'b0;
         rdata_reg     <= '0;
         req_wen_reg   <= 1'b0;
         req_addr_reg  <= '0;
         req_wdata_reg <= '0;
         req_wmask_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            LSU_IDLE: begin
               if (start) begin
                  cnt_reg   <= '0;
                  size_reg  <= size;
                  off_reg   <= addr[2:0];
                  fault_reg <= bad;
                  rdata_reg <= '0;
                  if (state_next == LSU_REQ) begin
                     req_wen_reg   <= wen;
                     req_addr_reg  <= {addr[63:3], 3'b000};
                     req_wdata_reg <= bus_wdata;
                     req_wmask_reg <= wen ? bus_wmask : 8'h00;
                  end
               end
            end
            LSU_REQ: begin
               cnt_reg <= cnt_reg + 32'd1;
               if (timeout_hit) fault_reg <= 1'b1;
            end
            LSU_RESP: begin
               cnt_reg <= cnt_reg + 32'd1;
               // A response arriving in the last allowed cycle still wins.
               if (mem_resp_valid) begin
                  if (!req_wen_reg) rdata_reg <= ld_data;
               end else if (timeout_hit) begin
                  fault_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign done          = (state_reg == LSU_DONE);
   assign mem_req_valid = (state_reg == LSU_REQ);
   assign fault         = fault_reg;
   assign rdata         = rdata_reg;
   assign mem_req_wen   = req_wen_reg;
   assign mem_req_addr  = req_addr_reg;
   assign mem_req_wdata = req_wdata_reg;
   assign mem_req_wmask = req_wmask_reg;

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Directed bench for ysyx_22050133_lsu: transaction-level expectations checked
// every cycle, plus literal checks on captured results.
module tb_ysyx_22050133_lsu;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        ren = 1'b0;
   logic        wen = 1'b0;
   logic [1:0]  size = 2'd0;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic        done;
   logic [63:0] rdata;
   logic        fault;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_wen;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid = 1'b0;
   logic [63:0] mem_resp_rdata = '0;

   ysyx_22050133_lsu #(.TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .ren            (ren),
      .wen            (wen),
      .size           (size),
      .addr           (addr),
      .wdata          (wdata),
      .done           (done),
      .rdata          (rdata),
      .fault          (fault),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_wen    (mem_req_wen),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit rst_q = 1'b1;

   // transaction model state
   int          t_start = -100;
   int          exp_done = -1;
   bit          exp_fault = 1'b0;
   logic [63:0] exp_rdata = '0;
   int          req_first = 1;
   int          req_last = 0;
   bit          exp_wen = 1'b0;
   logic [63:0] exp_addr = '0;
   logic [63:0] exp_wdata = '0;
   logic [7:0]  exp_wmask = '0;
   int          rdy_cyc = -1;
   int          resp_cyc = -1;
   int          stray_cyc = -1;

   // values captured from the DUT for literal checks
   int          cap_valid_cnt = 0;
   int          cap_done_cyc = -1;
   int          done_cnt = 0;
   bit          cap_fault = 1'b0;
   bit          cap_wen = 1'b0;
   logic [63:0] cap_rdata = '0;
   logic [63:0] cap_addr = '0;
   logic [63:0] cap_wdata = '0;
   logic [7:0]  cap_wmask = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] lane_mask(input int nb);
      if (nb >= 8) return {64{1'b1}};
      return (64'd1 << (8 * nb)) - 64'd1;
   endfunction

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   always @(negedge clk) begin
      mem_req_ready  = (cyc == rdy_cyc);
      mem_resp_valid = (cyc == resp_cyc) || (cyc == stray_cyc);
   end

   // per-cycle compare against the transaction model
   always @(posedge clk) begin
      bit exp_v;
      #1;
      if (rst_q) begin
         chk("rst_valid", {63'd0, mem_req_valid}, 64'd0);
         chk("rst_done",  {63'd0, done}, 64'd0);
         chk("rst_fault", {63'd0, fault}, 64'd0);
         chk("rst_rdata", rdata, 64'd0);
         chk("rst_wen",   {63'd0, mem_req_wen}, 64'd0);
         chk("rst_addr",  mem_req_addr, 64'd0);
         chk("rst_wdata", mem_req_wdata, 64'd0);
         chk("rst_wmask", {56'd0, mem_req_wmask}, 64'd0);
      end else begin
         exp_v = (cyc >= req_first) && (cyc <= req_last);
         chk("valid", {63'd0, mem_req_valid}, {63'd0, exp_v});
         if (exp_v) begin
            chk("req_wen",   {63'd0, mem_req_wen}, {63'd0, exp_wen});
            chk("req_addr",  mem_req_addr, exp_addr);
            chk("req_wdata", mem_req_wdata, exp_wdata);
            chk("req_wmask", {56'd0, mem_req_wmask}, {56'd0, exp_wmask});
         end
         chk("done", {63'd0, done}, {63'd0, (cyc == exp_done)});
         if (cyc == exp_done) chk("fault", {63'd0, fault}, {63'd0, exp_fault});
         if (cyc > t_start) chk("rdata", rdata, (cyc >= exp_done) ? exp_rdata : 64'd0);
      end
      if (mem_req_valid) begin
         cap_valid_cnt++;
         cap_wen   = mem_req_wen;
         cap_addr  = mem_req_addr;
         cap_wdata = mem_req_wdata;
         cap_wmask = mem_req_wmask;
      end
      if (done) begin
         done_cnt++;
         cap_done_cyc = cyc;
         cap_fault    = fault;
         cap_rdata    = rdata;
      end
   end

   // dr/ds: cycles before ready / after handshake before resp; negative = never
   task automatic start_txn(input bit r, input bit w, input logic [1:0] sz,
                            input logic [63:0] a, input logic [63:0] wd,
                            input logic [63:0] rsp, input int dr, input int ds,
                            input bit ign);
      int nb;
      int off;
      bit bad;
      bit noop;
      @(negedge clk);
      ren = r; wen = w; size = sz; addr = a; wdata = wd;
      mem_resp_rdata = rsp;
      start = 1'b1;
      t_start = cyc;
      nb   = 1 << sz;
      off  = int'(a % 64'd8);
      noop = !r && !w;
      bad  = (r && w) || (!noop && ((a % 64'(nb)) != 64'd0));
      cap_valid_cnt = 0;
      cap_done_cyc  = -1;
      exp_rdata = '0;
      rdy_cyc   = -1;
      resp_cyc  = -1;
      req_first = 1;
      req_last  = 0;
      if (noop || bad) begin
         exp_done  = t_start + 1;
         exp_fault = bad;
      end else begin
         req_first = t_start + 1;
         exp_wen   = w;
         exp_addr  = a & ~64'h7;
         exp_wmask = w ? 8'(((1 << nb) - 1) << off) : 8'h00;
         exp_wdata = wd << (8 * off);
         if (dr < 0 || ds < 0 || dr + ds + 2 > TO) begin
            exp_done  = t_start + TO + 1;
            exp_fault = 1'b1;
            if (dr >= 0 && dr < TO) begin
               rdy_cyc  = t_start + 1 + dr;
               req_last = rdy_cyc;
            end else begin
               req_last = t_start + TO;
            end
         end else begin
            rdy_cyc   = t_start + 1 + dr;
            req_last  = rdy_cyc;
            resp_cyc  = rdy_cyc + 1 + ds;
            exp_done  = resp_cyc + 1;
            exp_fault = 1'b0;
            if (r) exp_rdata = (rsp >> (8 * off)) & lane_mask(nb);
         end
      end
      $display("txn T=%0d ren=%0d wen=%0d size=%0d addr=%h wdata=%h done@%0d fault=%0d rdata=%h",
               t_start, r, w, sz, a, wd, exp_done, exp_fault, exp_rdata);
      @(negedge clk);
      start = 1'b0;
      if (ign) begin
         @(negedge clk);
         start = 1'b1; ren = 1'b1; wen = 1'b1; size = 2'd0; addr = 64'h3;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic wait_txn();
      int n = 0;
      while (cyc <= exp_done + 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_timeout cyc=%0d got=no_done want=done@%0d", cyc, exp_done);
      end
   endtask

   initial begin
      int dc;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // sb, ready and ack immediate
      start_txn(0, 1, 2'd0, 64'h8000_0005, 64'hAB, 64'h0, 0, 0, 0);
      wait_txn();
      chk("sb_addr",  cap_addr, 64'h8000_0000);
      chk("sb_wmask", {56'd0, cap_wmask}, 64'h20);
      chk("sb_wdata", cap_wdata, 64'h0000_AB00_0000_0000);
      chk("sb_lat",   64'(cap_done_cyc - t_start), 64'd3);
      chk("sb_fault", {63'd0, cap_fault}, 64'd0);

      // lh at offset 6
      start_txn(1, 0, 2'd1, 64'h8000_0006, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 0, 0);
      wait_txn();
      chk("lh_rdata", cap_rdata, 64'h0000_0000_0000_1234);
      chk("lh_wen",   {63'd0, cap_wen}, 64'd0);
      chk("lh_wmask", {56'd0, cap_wmask}, 64'd0);

      // ld with stalled ready, late response and an ignored mid-flight start
      dc = done_cnt;
      start_txn(1, 0, 2'd3, 64'h8000_0010, 64'h0, 64'hFEDC_BA98_7654_3210, 3, 2, 1);
      wait_txn();
      chk("ld_rdata", cap_rdata, 64'hFEDC_BA98_7654_3210);
      chk("ld_vcnt",  64'(cap_valid_cnt), 64'd4);
      chk("ld_dones", 64'(done_cnt - dc), 64'd1);

      // sw, lbu, misaligned and conflicting accesses, no-op
      start_txn(0, 1, 2'd2, 64'h8000_0004, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1, 1, 0);
      wait_txn();
      chk("sw_wmask", {56'd0, cap_wmask}, 64'hF0);
      chk("sw_wdata", cap_wdata, 64'hCAFE_F00D_0000_0000);
      start_txn(1, 0, 2'd0, 64'h8000_0003, 64'h0, 64'h1122_3344_5566_7788, 0, 1, 0);
      wait_txn();
      chk("lbu_rdata", cap_rdata, 64'h55);
      start_txn(1, 0, 2'd2, 64'h8000_0002, 64'h0, 64'h0, 0, 0, 0);
      wait_txn();
      chk("lw_mis_lat",   64'(cap_done_cyc - t_start), 64'd1);
      chk("lw_mis_fault", {63'd0, cap_fault}, 64'd1);
      chk("lw_mis_vcnt",  64'(cap_valid_cnt), 64'd0);
      start_txn(1, 1, 2'd2, 64'h8000_0000, 64'h0, 64'h0, 0, 0, 0);
      wait_txn();
      chk("rw_fault", {63'd0, cap_fault}, 64'd1);
      chk("rw_vcnt",  64'(cap_valid_cnt), 64'd0);
      start_txn(0, 1, 2'd3, 64'h8000_0004, 64'h1, 64'h0, 0, 0, 0);
      wait_txn();
      start_txn(0, 0, 2'd0, 64'h0, 64'h0, 64'h0, 0, 0, 0);
      wait_txn();
      chk("noop_fault", {63'd0, cap_fault}, 64'd0);

      // timeout with ready never asserted, then a stray response in IDLE
      start_txn(1, 0, 2'd3, 64'h8000_0020, 64'h0, 64'h0, -1, -1, 0);
      wait_txn();
      chk("to_lat",   64'(cap_done_cyc - t_start), 64'd9);
      chk("to_fault", {63'd0, cap_fault}, 64'd1);
      chk("to_vcnt",  64'(cap_valid_cnt), 64'd8);
      dc = done_cnt;
      mem_resp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      stray_cyc = cyc + 1;
      repeat (4) @(negedge clk);
      chk("stray_dones", 64'(done_cnt - dc), 64'd0);

      // reset while waiting in RESP, then a no-op
      start_txn(1, 0, 2'd3, 64'h8000_0008, 64'h0, 64'h0, 0, -1, 0);
      @(negedge clk);
      dc = done_cnt;
      rst = 1'b1;
      exp_done = -1; exp_rdata = '0; req_last = 0; resp_cyc = -1; rdy_cyc = -1;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("rst_dones", 64'(done_cnt - dc), 64'd0);
      start_txn(0, 0, 2'd0, 64'h0, 64'h0, 64'h0, 0, 0, 0);
      wait_txn();
      chk("post_rst_lat",   64'(cap_done_cyc - t_start), 64'd1);
      chk("post_rst_rdata", cap_rdata, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
